dwt_lift_sequencer: RTL and testbench
=====================================

Name: dwt_lift_sequencer

Overview:
- Controller for the floating-point lifting DWT datapath (`dwt`).
- Accepts sample triples on a valid/ready input.
- Steps the datapath mux selects s1..s6 through a fixed 4-phase microsequence. The datapath K-register chain clocks every cycle, so the four phases always run in consecutive cycles.
- Captures an/dn at the final phase into an output FIFO with valid/ready.
- Owns K-chain hygiene: flush after reset, zero operands when idle.

Parameters:
- OUT_DEPTH, 2, entries in the result FIFO (>=2).
- FLUSH_CYCLES, 3, cycles in_ready is held low after reset so the K2..K4 chain drains to zero.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset (see Behaviour)
- in_valid  input  1  sample triple valid
- in_ready  output  1  sequencer accepts the triple this cycle
- in_even  input  32  IEEE-754 even sample; driven to y2n
- in_odd  input  32  IEEE-754 odd sample; driven to y2n_1
- in_next  input  32  IEEE-754 next even sample; driven to y2na
- y2n, y2n_1, y2na  output  32 each  registered operands to the datapath
- s1  output  2  datapath select
- s2, s3, s4, s5, s6  output  1 each  datapath selects
- an, dn  input  32 each  datapath results (combinational from the operands and selects)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes the head
- out_approx  output  32  head approximation coefficient
- out_detail  output  32  head detail coefficient
- busy  output  1  state != IDLE or flush in progress
- result_cnt  output  CNT_W  results pushed since reset; wraps

Behaviour:
- Reset is synchronous and active-high, on the clk rising edge; one clock domain only.
  - Reset values: state=IDLE; flush counter=FLUSH_CYCLES; FIFO empty; out_valid=0; out_approx=out_detail=0; y2n=y2n_1=y2na=0; selects at PH0 values; result_cnt=0; in_ready=0; busy=1.
- Reset mid-sequence aborts the sequence: the in-flight result is discarded, FIFO contents are dropped, and the flush restarts.
- FLUSH: decrements one per cycle with selects at PH0 values and zero operands. K1=0, so K2..K4 become zero after 3 cycles. busy=1, in_ready=0. Exits to IDLE at count 0.
- States and select vectors (s1,s2,s3,s4,s5,s6):
  - IDLE: 00,0,0,0,0,1 with zero operands.
  - PH0: 00,0,0,0,0,1.
  - PH1: 01,1,1,1,1,1.
  - PH2: 10,1,1,1,1,0.
  - PH3: 10,1,1,1,1,0.
- Transitions:
  - IDLE -> PH0 on accept.
  - PH0 -> PH1 -> PH2 -> PH3 unconditionally; no stalls.
  - PH3 -> PH0 on accept in PH3 (back-to-back), else PH3 -> IDLE.
- Accept = in_valid & in_ready.
  - Operands are registered on the accept edge.
  - Operands hold through PH3 and return to zero on entry to IDLE.
- in_ready is registered-path only, with no combinational dependency on out_ready:
  - In IDLE: fifo_count < OUT_DEPTH.
  - In PH3: fifo_count+1 < OUT_DEPTH.
  - Otherwise: 0.
- Capture: at the clk edge ending PH3, push {an, dn} into the FIFO and increment result_cnt.
  - result_cnt wraps from 2^CNT_W-1 to 0.
  - Push is guaranteed to find room by the in_ready rule; an overflow push is a design error, asserted in simulation.
- Latency: accept at edge T (in_valid sampled high at T), PH0 occupies cycle T..T+1, PH3 ends at T+4, out_valid high from T+4 when the FIFO was empty.
- Throughput: 1 result per 4 cycles when out_ready=1.
- FIFO:
  - First-word fall-through; head drives out_approx/out_detail.
  - Pop = out_valid & out_ready.
  - Simultaneous push and pop on a full FIFO is legal and keeps the count.
  - When empty, out_valid=0 and data holds its last value.
- Back-to-back accepts intentionally carry K-chain history from the previous sample (lifting state). After any IDLE gap of >=3 cycles the history is zero.
- Float arithmetic is entirely in the datapath; the sequencer never inspects values.

Test Plan:
- Reset, then hold in_valid=1 from cycle 0 -> in_ready=0 for cycles 0..2 (FLUSH_CYCLES=3) and 1 at cycle 3. Accept at cycle 3 gives selects PH0..PH3 exactly per the table in cycles 4..7; out_valid rises at cycle 8.
- Single triple of zeros (0x00000000 x3) after flush -> out_approx=0x00000000, out_detail=0x00000000, result_cnt=1, out_valid high for exactly 1 cycle with out_ready=1.
- 8 triples streamed with in_valid=1, out_ready=1 -> accepts exactly every 4 cycles (no IDLE visit between). Results in order; result_cnt=8. The check is against the golden model of the datapath fed the same select trace.
- out_ready=0 with in_valid=1 continuous:
  - 2 triples accepted, then in_ready stays 0 and FIFO holds 2 (out_valid=1, head is the first result).
  - Raise out_ready for one cycle -> one pop; in_ready=1 next IDLE cycle.
- Assert rst for one cycle during PH2 of a sequence -> next cycle out_valid=0, busy=1, selects at PH0 values, and no result is ever emitted for the aborted triple.
- Preload result_cnt near wrap via 65535 completed results (or force) -> next push makes result_cnt 0x0000 with no effect on the data path.

Source files
------------

// File: rtl/dwt_lift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dwt_lift_sequencer
// Purpose  : Sequences the lifting DWT datapath through a 4-phase
//            microsequence and buffers an/dn results in a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module dwt_lift_sequencer #(
  parameter int OUT_DEPTH    = 2,
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_even,
  input  logic [31:0]      in_odd,
  input  logic [31:0]      in_next,
  output logic [31:0]      y2n,
  output logic [31:0]      y2n_1,
  output logic [31:0]      y2na,
  output logic [1:0]       s1,
  output logic             s2,
  output logic             s3,
  output logic             s4,
  output logic             s5,
  output logic             s6,
  input  logic [31:0]      an,
  input  logic [31:0]      dn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_approx,
  output logic [31:0]      out_detail,
  output logic             busy,
  output logic [CNT_W-1:0] result_cnt
);

  localparam int c_cw = $clog2(OUT_DEPTH + 1);
  localparam int c_pw = $clog2(OUT_DEPTH);
  localparam int c_fw = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  localparam logic [c_cw-1:0] c_depth      = c_cw'(OUT_DEPTH);
  localparam logic [c_cw-1:0] c_depth_m1   = c_cw'(OUT_DEPTH - 1);
  localparam logic [c_pw-1:0] c_last_ptr   = c_pw'(OUT_DEPTH - 1);
  localparam logic [c_fw-1:0] c_flush_init = c_fw'(FLUSH_CYCLES);

  // {s1[1:0], s2, s3, s4, s5, s6}
  localparam logic [6:0] c_sel_ph0 = 7'b00_0_0_0_0_1;
  localparam logic [6:0] c_sel_ph1 = 7'b01_1_1_1_1_1;
  localparam logic [6:0] c_sel_ph2 = 7'b10_1_1_1_1_0;

  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_ph0  = 3'd1,
    st_ph1  = 3'd2,
    st_ph2  = 3'd3,
    st_ph3  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_fw-1:0]   r_flush;
  logic [c_fw-1:0]   w_flush_nxt;
  logic [c_cw-1:0]   r_count;
  logic [c_cw-1:0]   w_count_nxt;
  logic [c_pw-1:0]   r_rd_ptr;
  logic [c_pw-1:0]   r_wr_ptr;
  logic [63:0]       r_mem [OUT_DEPTH];
  logic [63:0]       r_last;
  logic [63:0]       w_head;
  logic [31:0]       r_y2n;
  logic [31:0]       r_y2n_1;
  logic [31:0]       r_y2na;
  logic [6:0]        r_sel;
  logic [6:0]        w_sel_nxt;
  logic              r_in_ready;
  logic              w_ready_nxt;
  logic              r_busy;
  logic [CNT_W-1:0]  r_result_cnt;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
    ptr_inc = (p == c_last_ptr) ? '0 : p + c_pw'(1);
  endfunction

  always_comb begin
    w_accept    = in_valid & r_in_ready;
    w_push      = (r_state == st_ph3);
    w_pop       = (r_count != '0) & out_ready;
    w_count_nxt = r_count + c_cw'(w_push) - c_cw'(w_pop);
    w_flush_nxt = (r_flush != '0) ? r_flush - c_fw'(1) : r_flush;

    w_state_nxt = st_idle;
    case (r_state)
      st_idle: w_state_nxt = w_accept ? st_ph0 : st_idle;
      st_ph0:  w_state_nxt = st_ph1;
      st_ph1:  w_state_nxt = st_ph2;
      st_ph2:  w_state_nxt = st_ph3;
      st_ph3:  w_state_nxt = w_accept ? st_ph0 : st_idle;
      default: w_state_nxt = st_idle;
    endcase

    w_sel_nxt = c_sel_ph0;
    case (w_state_nxt)
      st_ph1:         w_sel_nxt = c_sel_ph1;
      st_ph2, st_ph3: w_sel_nxt = c_sel_ph2;
      default:        w_sel_nxt = c_sel_ph0;
    endcase

    // Readiness is decided one cycle ahead so in_ready leaves a flop.
    w_ready_nxt = (w_flush_nxt == '0) &&
                  (((w_state_nxt == st_idle) && (w_count_nxt < c_depth)) ||
                   ((w_state_nxt == st_ph3)  && (w_count_nxt < c_depth_m1)));

    w_head = (r_count != '0) ? r_mem[r_rd_ptr] : r_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= st_idle;
      r_flush      <= c_flush_init;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_last       <= '0;
      r_y2n        <= '0;
      r_y2n_1      <= '0;
      r_y2na       <= '0;
      r_sel        <= c_sel_ph0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b1;
      r_result_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_flush    <= w_flush_nxt;
      r_count    <= w_count_nxt;
      r_sel      <= w_sel_nxt;
      r_in_ready <= w_ready_nxt;
      r_busy     <= (w_state_nxt != st_idle) || (w_flush_nxt != '0);
      r_last     <= w_head;
      if (w_push) begin
        r_wr_ptr     <= ptr_inc(r_wr_ptr);
        r_result_cnt <= r_result_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      // Idle operands stay zero so the K-chain drains between sequences.
      if (w_accept) begin
        r_y2n   <= in_even;
        r_y2n_1 <= in_odd;
        r_y2na  <= in_next;
      end else if (w_state_nxt == st_idle) begin
        r_y2n   <= '0;
        r_y2n_1 <= '0;
        r_y2na  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {an, dn};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == c_depth)));

  assign in_ready                   = r_in_ready;
  assign busy                       = r_busy;
  assign y2n                        = r_y2n;
  assign y2n_1                      = r_y2n_1;
  assign y2na                       = r_y2na;
  assign {s1, s2, s3, s4, s5, s6}   = r_sel;
  assign out_valid                  = (r_count != '0);
  assign {out_approx, out_detail}   = w_head;
  assign result_cnt                 = r_result_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dwt_lift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dwt_lift_sequencer
// Purpose  : Randomized bench for dwt_lift_sequencer with a stand-in datapath
//            and a phase-schedule reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dwt_lift_sequencer;

  localparam int OUT_DEPTH    = 2;
  localparam int FLUSH_CYCLES = 3;
  // Narrow counter so the wrap is reached within a short run.
  localparam int CNT_W        = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_even = '0, in_odd = '0, in_next = '0;
  logic [31:0]      y2n, y2n_1, y2na;
  logic [1:0]       s1;
  logic             s2, s3, s4, s5, s6;
  logic [31:0]      an, dn;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_approx, out_detail;
  logic             busy;
  logic [CNT_W-1:0] result_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  dwt_lift_sequencer #(
    .OUT_DEPTH(OUT_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_even(in_even), .in_odd(in_odd), .in_next(in_next),
    .y2n(y2n), .y2n_1(y2n_1), .y2na(y2na),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6),
    .an(an), .dn(dn), .out_valid(out_valid), .out_ready(out_ready),
    .out_approx(out_approx), .out_detail(out_detail),
    .busy(busy), .result_cnt(result_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Stand-in datapath: sel = {s1, s2, s3, s4, s5, s6}.
  function automatic logic [31:0] dp_k1(input logic [31:0] a, b, c,
                                        input logic [6:0] sel, input logic [31:0] k4);
    dp_k1 = (a ^ {b[15:0], b[31:16]}) + ((sel[6:5] == 2'b01) ? c : 32'd0)
            + (sel[3] ? k4 : 32'd0);
  endfunction

  function automatic logic [63:0] dp_out(input logic [31:0] a, b, c, input logic [6:0] sel,
                                         input logic [31:0] k2, k3, k4);
    logic [31:0] ra, rd;
    ra = a + (sel[2] ? k2 : 32'd0) + ((sel[6:5] == 2'b10) ? k3 : 32'd0);
    rd = b ^ (sel[1] ? k4 : 32'd0) ^ (sel[4] ? {c[7:0], c[31:8]} : 32'd0)
           ^ {31'd0, sel[0]};
    dp_out = {ra, rd};
  endfunction

  function automatic logic [6:0] sel_of(input int ph);
    case (ph)
      1:       sel_of = 7'b01_1_1_1_1_1;
      2, 3:    sel_of = 7'b10_1_1_1_1_0;
      default: sel_of = 7'b00_0_0_0_0_1;
    endcase
  endfunction

  logic [31:0] k1, k2, k3, k4;
  logic [6:0]  w_sel;
  assign w_sel = {s1, s2, s3, s4, s5, s6};

  always_comb {an, dn} = dp_out(y2n, y2n_1, y2na, w_sel, k2, k3, k4);

  // Datapath registers are not reset: scramble them so only the flush cleans them.
  always @(posedge clk) begin
    if (rst) begin
      k1 <= $urandom; k2 <= $urandom; k3 <= $urandom; k4 <= $urandom;
    end else begin
      k1 <= dp_k1(y2n, y2n_1, y2na, w_sel, k4);
      k2 <= k1; k3 <= k2; k4 <= k3;
    end
  end

  // Reference model: phase schedule per cycle (-1 idle), FIFO as a queue.
  int               m_ph = -1;
  int               m_flush = FLUSH_CYCLES;
  logic [31:0]      m_a = '0, m_b = '0, m_c = '0;
  logic [31:0]      mk1 = '0, mk2 = '0, mk3 = '0, mk4 = '0;
  logic [63:0]      m_q[$];
  logic [63:0]      m_last = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  bit               m_acc = 1'b0;

  always @(negedge clk) begin : mon
    logic        exp_ready;
    logic [6:0]  sel;
    logic [63:0] res;
    logic [63:0] head;
    logic [31:0] nk1;
    if (rst) begin
      m_ph = -1; m_flush = FLUSH_CYCLES; m_a = '0; m_b = '0; m_c = '0;
      mk1 = '0; mk2 = '0; mk3 = '0; mk4 = '0;
      m_q.delete(); m_last = '0; m_cnt = '0; m_acc = 1'b0; cyc = 0;
    end else begin
      sel = sel_of(m_ph);
      exp_ready = (m_flush == 0) &&
                  ((m_ph < 0 && m_q.size() < OUT_DEPTH) ||
                   (m_ph == 3 && m_q.size() + 1 < OUT_DEPTH));
      head = (m_q.size() > 0) ? m_q[0] : m_last;
      chk("in_ready",   64'(in_ready), 64'(exp_ready));
      chk("busy",       64'(busy), 64'((m_ph >= 0) || (m_flush != 0)));
      chk("selects",    64'(w_sel), 64'(sel));
      chk("y2n",        64'(y2n), 64'(m_a));
      chk("y2n_1_y2na", {y2n_1, y2na}, {m_b, m_c});
      chk("out_valid",  64'(out_valid), 64'(m_q.size() > 0));
      chk("out_data",   {out_approx, out_detail}, head);
      chk("result_cnt", 64'(result_cnt), 64'(m_cnt));

      res = dp_out(m_a, m_b, m_c, sel, mk2, mk3, mk4);
      nk1 = dp_k1(m_a, m_b, m_c, sel, mk4);
      m_acc = in_valid && exp_ready;
      if (m_q.size() > 0 && out_ready) m_last = m_q.pop_front();
      if (m_ph == 3) begin
        m_q.push_back(res);
        m_cnt = m_cnt + 1'b1;
      end
      mk4 = mk3; mk3 = mk2; mk2 = mk1; mk1 = nk1;
      if (m_ph >= 0 && m_ph < 3) begin
        m_ph = m_ph + 1;
      end else if (m_acc) begin
        m_ph = 0; m_a = in_even; m_b = in_odd; m_c = in_next;
      end else begin
        m_ph = -1; m_a = '0; m_b = '0; m_c = '0;
      end
      if (m_flush > 0) m_flush = m_flush - 1;
      cyc++;
    end
  end

  task automatic drive(input logic v, input logic r, input logic zero);
    in_valid  = v;
    out_ready = r;
    in_even   = zero ? 32'd0 : $urandom;
    in_odd    = zero ? 32'd0 : $urandom;
    in_next   = zero ? 32'd0 : $urandom;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  nv;
    bit  got;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Flush timing, then back-to-back streaming.
    for (int i = 0; i <= 36; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      if (i == 2)  chk("flush_ready_c2", 64'(in_ready), 64'd0);
      if (i == 3)  chk("flush_ready_c3", 64'(in_ready), 64'd1);
      if (i == 5)  chk("ph1_s1_c5", 64'(s1), 64'd1);
      if (i == 7)  chk("out_valid_c7", 64'(out_valid), 64'd0);
      if (i == 8)  chk("out_valid_c8", 64'(out_valid), 64'd1);
      if (i == 36) chk("stream_cnt", 64'(result_cnt), 64'd8);
      adv();
    end
    for (int i = 0; i < 12; i++) begin drive(1'b0, 1'b1, 1'b0); adv(); end

    // Single all-zero triple.
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      adv();
      got = m_acc;
    end
    chk("zero_accept", 64'(got), 64'd1);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      if (out_valid) begin
        nv++;
        chk("zero_data", {out_approx, out_detail}, 64'd0);
      end
      adv();
    end
    chk("zero_pulse_len", 64'(nv), 64'd1);

    // Back-pressure: FIFO fills, in_ready stays low, one pop reopens input.
    for (int i = 0; i < 24; i++) begin drive(1'b1, 1'b0, 1'b0); adv(); end
    @(negedge clk);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    adv();
    drive(1'b1, 1'b1, 1'b0);
    adv();
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("pop_reopens", 64'(in_ready), 64'd1);
    adv();
    for (int i = 0; i < 12; i++) begin drive(1'b1, 1'b0, 1'b0); adv(); end
    for (int i = 0; i < 12; i++) begin drive(1'b0, 1'b1, 1'b0); adv(); end

    // Reset during PH2 aborts the sequence.
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (m_ph == 2) got = 1'b1;
      else adv();
    end
    chk("reach_ph2", 64'(got), 64'd1);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_selects", 64'(w_sel), 64'h01);
    adv();

    // Random traffic; long enough for result_cnt to wrap.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
      adv();
    end
    for (int i = 0; i < 16; i++) begin drive(1'b0, 1'b1, 1'b0); adv(); end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
